// File: rtl/uart_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_mem_pkg
// Description : Shared types and defaults for the UART memory loader. Holds
//               the loader and dump-sequencer state encodings, the default
//               image sizes and a helper that sizes byte counters.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_mem_pkg;

  localparam int DEF_ADDR_W         = 19;
  localparam int DEF_INS_DEPTH      = 256;
  localparam int DEF_IMG_LOAD_BYTES = 307200;
  localparam int DEF_DUMP_BASE      = 307200;
  localparam int DEF_IMG_DUMP_BYTES = 76800;
  localparam int DEF_RD_LAT         = 2;

  // Top-level loader phases; the dump itself is sequenced by uart_dump_seq.
  typedef enum logic [1:0] {
    ST_LOAD_INS = 2'd0,
    ST_LOAD_IMG = 2'd1,
    ST_RUN      = 2'd2,
    ST_DUMP     = 2'd3
  } ldr_state_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_RD   = 2'd1,
    DS_TX   = 2'd2,
    DS_ACK  = 2'd3
  } dump_state_e;

  // Width of a counter that spans 0..n-1 (never narrower than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_dump_seq.sv
`default_nettype none
// ============================================================================
// Module      : uart_dump_seq
// Description : Streams IMG_DUMP_BYTES bytes of image RAM, starting at
//               DUMP_BASE, out through the UART TX byte engine.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle pulse that begins a dump at byte 0
//   rd_q        : image RAM read data (RD_LAT cycles after rd_addr)
//   tx_busy     : TX engine busy, rises the cycle after tx_start
//   rd_addr     : image RAM read address, valid while rd_active
//   rd_active   : high while the sequencer owns the image RAM address
//   tx_data     : byte to transmit, held from capture to next capture
//   tx_start    : one-cycle transmit request
//   done        : one-cycle pulse as the last byte is accepted by TX
// Revision    : 1.0 - initial release
// ============================================================================
module uart_dump_seq
  import uart_mem_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DUMP_BASE      = DEF_DUMP_BASE,
  parameter int IMG_DUMP_BYTES = DEF_IMG_DUMP_BYTES,
  parameter int RD_LAT         = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rd_q,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_active,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              done
);

  localparam int DMP_W = cnt_w(IMG_DUMP_BYTES);
  localparam int LAT_W = cnt_w(RD_LAT + 1);

  dump_state_e      state_q, state_d;
  logic [DMP_W-1:0] dump_cnt_q, dump_cnt_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;

  always_comb begin
    state_d    = state_q;
    dump_cnt_d = dump_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    done       = 1'b0;
    case (state_q)
      DS_IDLE: begin
        if (start) begin
          dump_cnt_d = '0;
          lat_cnt_d  = '0;
          state_d    = DS_RD;
        end
      end
      // Address is held for RD_LAT+1 cycles so the data captured on the
      // last one is the word that was addressed on the first one.
      DS_RD: begin
        if (lat_cnt_q == LAT_W'(RD_LAT)) begin
          tx_data_d = rd_q;
          lat_cnt_d = '0;
          state_d   = DS_TX;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      DS_TX: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = DS_ACK;
        end
      end
      // tx_busy going high is the acceptance of the byte; the next read is
      // launched immediately so it overlaps the serial transmission.
      DS_ACK: begin
        if (tx_busy) begin
          if (dump_cnt_q == DMP_W'(IMG_DUMP_BYTES - 1)) begin
            done       = 1'b1;
            dump_cnt_d = '0;
            state_d    = DS_IDLE;
          end else begin
            dump_cnt_d = dump_cnt_q + DMP_W'(1);
            state_d    = DS_RD;
          end
        end
      end
      default: state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DS_IDLE;
      dump_cnt_q <= '0;
      lat_cnt_q  <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dump_cnt_q <= dump_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign rd_addr   = ADDR_W'(DUMP_BASE) + ADDR_W'(dump_cnt_q);
  assign rd_active = (state_q != DS_IDLE);
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;

endmodule
`default_nettype wire

// File: rtl/uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_mem_loader
// Description : Loads instruction RAM then image RAM from the UART RX byte
//               stream, launches the CPU, waits for it to finish and streams
//               the processed image region back out through UART TX. Owns
//               all port-b traffic of memory_unit.
//   clk, rst_n        : clock, asynchronous active-low reset
//   rx_data/rx_valid  : received byte and its one-cycle strobe
//   tx_data/tx_start  : byte to send and its one-cycle request
//   tx_busy           : TX engine busy
//   M_I_*_UART        : instruction RAM write port
//   MI_IMG_*_UART     : image RAM write/read port
//   cpu_start         : one-cycle CPU launch pulse
//   cpu_done          : CPU finished (level, looked at only in RUN)
//   rx_overrun        : sticky, byte arrived while not loading
//   frame_done        : one-cycle pulse when the last byte is accepted by TX
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mem_loader
  import uart_mem_pkg::*;
#(
  parameter int INS_DEPTH      = DEF_INS_DEPTH,
  parameter int IMG_LOAD_BYTES = DEF_IMG_LOAD_BYTES,
  parameter int DUMP_BASE      = DEF_DUMP_BASE,
  parameter int IMG_DUMP_BYTES = DEF_IMG_DUMP_BYTES,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int RD_LAT         = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [7:0]        M_I_data_UART,
  output logic [7:0]        M_I_addr_UART,
  output logic              M_I_we_UART,
  output logic [7:0]        MI_IMG_data_UART,
  output logic [ADDR_W-1:0] MI_IMG_addr_UART,
  output logic              MI_IMG_we_UART,
  input  logic [7:0]        MI_IMG_q_UART,
  output logic              cpu_start,
  input  logic              cpu_done,
  output logic              rx_overrun,
  output logic              frame_done
);

  localparam int INS_W = cnt_w(INS_DEPTH);
  localparam int IMG_W = cnt_w(IMG_LOAD_BYTES);

  // Elaboration-time legality of the parameter set.
  if (INS_DEPTH < 1 || INS_DEPTH > 256) begin : g_bad_ins_depth
    $error("uart_mem_loader: INS_DEPTH must be 1..256");
  end
  if (IMG_LOAD_BYTES < 1 || longint'(IMG_LOAD_BYTES) > (longint'(1) << ADDR_W)) begin : g_bad_img_load
    $error("uart_mem_loader: IMG_LOAD_BYTES does not fit the image address space");
  end
  if (IMG_DUMP_BYTES < 1 ||
      longint'(DUMP_BASE) + longint'(IMG_DUMP_BYTES) > (longint'(1) << ADDR_W)) begin : g_bad_dump_window
    $error("uart_mem_loader: DUMP_BASE+IMG_DUMP_BYTES wraps the image address space");
  end
  if (RD_LAT < 0) begin : g_bad_rd_lat
    $error("uart_mem_loader: RD_LAT must be non-negative");
  end

  ldr_state_e        state_q, state_d;
  logic [INS_W-1:0]  ins_cnt_q, ins_cnt_d;
  logic [IMG_W-1:0]  img_cnt_q, img_cnt_d;
  logic [7:0]        ins_addr_q, ins_addr_d;
  logic [7:0]        ins_data_q, ins_data_d;
  logic              ins_we_q, ins_we_d;
  logic [ADDR_W-1:0] img_addr_q, img_addr_d;
  logic [7:0]        img_data_q, img_data_d;
  logic              img_we_q, img_we_d;
  logic              cpu_start_q, cpu_start_d;
  logic              overrun_q, overrun_d;
  logic              frame_done_q, frame_done_d;

  logic              dump_start;
  logic              dump_done;
  logic              dump_active;
  logic [ADDR_W-1:0] dump_addr;

  always_comb begin
    state_d      = state_q;
    ins_cnt_d    = ins_cnt_q;
    img_cnt_d    = img_cnt_q;
    ins_addr_d   = ins_addr_q;
    ins_data_d   = ins_data_q;
    ins_we_d     = 1'b0;
    img_addr_d   = img_addr_q;
    img_data_d   = img_data_q;
    img_we_d     = 1'b0;
    // The state already moved to RUN when the final image write was issued,
    // so an image write slot seen in RUN is that final write.
    cpu_start_d  = (state_q == ST_RUN) && img_we_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    dump_start   = 1'b0;
    case (state_q)
      ST_LOAD_INS: begin
        if (rx_valid) begin
          ins_we_d   = 1'b1;
          ins_addr_d = 8'(ins_cnt_q);
          ins_data_d = rx_data;
          if (ins_cnt_q == INS_W'(INS_DEPTH - 1)) begin
            ins_cnt_d = '0;
            state_d   = ST_LOAD_IMG;
          end else begin
            ins_cnt_d = ins_cnt_q + INS_W'(1);
          end
        end
      end
      ST_LOAD_IMG: begin
        if (rx_valid) begin
          img_we_d   = 1'b1;
          img_addr_d = ADDR_W'(img_cnt_q);
          img_data_d = rx_data;
          if (img_cnt_q == IMG_W'(IMG_LOAD_BYTES - 1)) begin
            img_cnt_d = '0;
            state_d   = ST_RUN;
          end else begin
            img_cnt_d = img_cnt_q + IMG_W'(1);
          end
        end
      end
      // cpu_done is only trusted once the launch pulse has gone out, so a
      // level left over from before the launch cannot skip the CPU run.
      ST_RUN: begin
        if (rx_valid) overrun_d = 1'b1;
        if (cpu_done && !img_we_q && !cpu_start_q) begin
          dump_start = 1'b1;
          state_d    = ST_DUMP;
        end
      end
      ST_DUMP: begin
        if (rx_valid) overrun_d = 1'b1;
        if (dump_done) begin
          frame_done_d = 1'b1;
          overrun_d    = 1'b0;
          ins_cnt_d    = '0;
          img_cnt_d    = '0;
          state_d      = ST_LOAD_INS;
        end
      end
      default: state_d = ST_LOAD_INS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD_INS;
      ins_cnt_q    <= '0;
      img_cnt_q    <= '0;
      ins_addr_q   <= '0;
      ins_data_q   <= '0;
      ins_we_q     <= 1'b0;
      img_addr_q   <= '0;
      img_data_q   <= '0;
      img_we_q     <= 1'b0;
      cpu_start_q  <= 1'b0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ins_cnt_q    <= ins_cnt_d;
      img_cnt_q    <= img_cnt_d;
      ins_addr_q   <= ins_addr_d;
      ins_data_q   <= ins_data_d;
      ins_we_q     <= ins_we_d;
      img_addr_q   <= img_addr_d;
      img_data_q   <= img_data_d;
      img_we_q     <= img_we_d;
      cpu_start_q  <= cpu_start_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  uart_dump_seq #(
    .ADDR_W         (ADDR_W),
    .DUMP_BASE      (DUMP_BASE),
    .IMG_DUMP_BYTES (IMG_DUMP_BYTES),
    .RD_LAT         (RD_LAT)
  ) u_dump_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (dump_start),
    .rd_q      (MI_IMG_q_UART),
    .tx_busy   (tx_busy),
    .rd_addr   (dump_addr),
    .rd_active (dump_active),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .done      (dump_done)
  );

  assign M_I_data_UART    = ins_data_q;
  assign M_I_addr_UART    = ins_addr_q;
  assign M_I_we_UART      = ins_we_q;
  assign MI_IMG_data_UART = img_data_q;
  assign MI_IMG_addr_UART = dump_active ? dump_addr : img_addr_q;
  assign MI_IMG_we_UART   = img_we_q;
  assign cpu_start        = cpu_start_q;
  assign rx_overrun       = overrun_q;
  assign frame_done       = frame_done_q;

endmodule
`default_nettype wire
